// File: rtl/lutram_pattern_tester.sv
// lutram_pattern_tester
// Self-checking sequencer for distributed-RAM primitives. It runs three phases
// over every address: clear, pattern write, then read-back. In the read-back
// phase it compares the single-port and dual-port outputs against the expected
// pattern. The RAM itself is outside this block and is wired to the ram_* ports.
// The tick input throttles stepping, so the RAM write clock stays on clk.
module lutram_pattern_tester #(
   parameter int A_WIDTH      = 5,
   parameter int D_WIDTH      = 1,
   parameter int READ_LATENCY = 0,
   parameter int ERR_WIDTH    = A_WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 start,
   input  logic [1:0]           mode,
   output logic                 ram_we,
   output logic [A_WIDTH-1:0]   ram_addr,
   output logic [A_WIDTH-1:0]   ram_raddr,
   output logic [D_WIDTH-1:0]   ram_wdata,
   input  logic [D_WIDTH-1:0]   ram_spo,
   input  logic [D_WIDTH-1:0]   ram_dpo,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_WIDTH-1:0] err_count,
   output logic [A_WIDTH-1:0]   first_err_addr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [A_WIDTH-1:0]   ADDR_LAST = '1;
   localparam logic [A_WIDTH-1:0]   ADDR_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;
   localparam logic [ERR_WIDTH-1:0] ERR_ONE   = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

   state_t             state;
   logic [A_WIDTH-1:0] addr;
   logic [1:0]         mode_q;
   logic               start_ok;
   logic               addr_last;

   // Read-back pipeline for a registered-output RAM
   logic               rd_valid_q;
   logic [A_WIDTH-1:0] rd_addr_q;

   // Compare stage, valid once per read-back address
   logic               chk_valid;
   logic [A_WIDTH-1:0] chk_addr;
   logic [D_WIDTH-1:0] chk_exp;
   logic               mismatch;

   // Expected data for address a. The address is zero-extended or truncated to
   // D_WIDTH before the mode-specific transform is applied.
   function automatic logic [D_WIDTH-1:0] pat(input logic [1:0] m,
                                              input logic [A_WIDTH-1:0] a);
      logic [D_WIDTH-1:0] a_ext;
      logic [D_WIDTH-1:0] p;
      a_ext = D_WIDTH'(a);
      p     = '0;
      case (m)
         2'd0: p = a_ext;
         2'd1: begin
            for (int i = 0; i < D_WIDTH; i++) p[i] = a[0] ^ i[0];
         end
         2'd2: p = ~a_ext;
         default: p = '1;
      endcase
      return p;
   endfunction

   assign start_ok  = start && (state == S_IDLE || state == S_DONE);
   assign addr_last = (addr == ADDR_LAST);

   // Phase sequencer and address counter. start is accepted whether or not
   // tick is high. Every other step waits for tick.
   // NOTE: state registers use non-blocking assignment so every always_ff
   // samples the pre-edge values, regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         addr   <= '0;
         mode_q <= 2'd0;
      end else if (start_ok) begin
         state  <= S_CLEAR;
         addr   <= '0;
         mode_q <= mode;
      end else if (tick) begin
         case (state)
            S_CLEAR: begin
               addr <= addr + ADDR_ONE;
               if (addr_last) state <= S_WRITE;
            end
            S_WRITE: begin
               addr <= addr + ADDR_ONE;
               if (addr_last) state <= S_READ;
            end
            S_READ: begin
               addr <= addr + ADDR_ONE;
               if (addr_last) state <= (READ_LATENCY == 1) ? S_DRAIN : S_DONE;
            end
            S_DRAIN: state <= S_DONE;
            default: ;
         endcase
      end
   end

   // Delay the read address and its tick flag by one cycle, to line up with a
   // RAM that has a registered output
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         rd_valid_q <= tick && (state == S_READ);
         rd_addr_q  <= addr;
      end
   end

   // Select the compare address for the configured read latency. Each address
   // counts as one error at most, however many ports disagree.
   // NOTE: every always_comb output gets a default first, so that no path
   // leaves a value held and no latch is inferred.
   always_comb begin
      chk_valid = 1'b0;
      chk_addr  = '0;
      if (READ_LATENCY == 1) begin
         chk_valid = rd_valid_q;
         chk_addr  = rd_addr_q;
      end else begin
         chk_valid = tick && (state == S_READ);
         chk_addr  = addr;
      end
      chk_exp  = pat(mode_q, chk_addr);
      mismatch = (ram_spo != chk_exp) || (ram_dpo != chk_exp);
   end

   // Saturating error counter. The first failing address is captured only
   // while the count is still zero.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (chk_valid && mismatch) begin
         if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
         if (err_count == '0) first_err_addr <= chk_addr;
      end
   end

   // Write data: zeros while clearing, the pattern while writing, zero otherwise
   always_comb begin
      ram_wdata = '0;
      if (state == S_WRITE) ram_wdata = pat(mode_q, addr);
   end

   assign ram_we    = tick && (state == S_CLEAR || state == S_WRITE);
   assign ram_addr  = addr;
   assign ram_raddr = addr;
   assign busy      = (state == S_CLEAR) || (state == S_WRITE) ||
                      (state == S_READ)  || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign pass      = done && (err_count == '0);

endmodule
